pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 27 ++
 rtl/pipeline_ctrl.sv | 107 ++++++++++
 tb/tb_pipeline_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: stage stall requests, multi-cycle EX handshake,
// flush/redirect, and the resulting stall vector plus sequencer status.
interface pipeline_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_len;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
  logic [31:0] stall_cnt;

  modport master (
    output stallreq_if, stallreq_id, stallreq_mem, mc_start, mc_len, flush_req, flush_pc,
    input  stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_mem, mc_start, mc_len, flush_req, flush_pc,
    output stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with a multi-cycle EX sequencer and a
// saturating stalled-cycle counter. Stall/flush/redirect respond same-cycle.
module pipeline_ctrl (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int unsigned LEN_W = 6;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned STG_W = 6;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               ex_req;
  logic               mc_done;
  logic [STG_W-1:0]   stall;
  logic               flush;
  logic [31:0]        new_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Sequencer: holds EX for all but the last cycle of a multi-cycle op,
  // freezing its countdown while MEM is waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_req  = 1'b0;
    mc_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mc_start && (bus.mc_len >= LEN_W'(2))) begin
          ex_req  = 1'b1;
          state_d = BUSY;
          cnt_d   = bus.mc_len - LEN_W'(1);
        end
      end
      BUSY: begin
        if (cnt_q > LEN_W'(1)) begin
          ex_req = 1'b1;
          if (!bus.stallreq_mem) cnt_d = cnt_q - LEN_W'(1);
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (!bus.stallreq_mem) begin
          mc_done = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_req) begin
      state_d = IDLE;
      cnt_d   = '0;
      mc_done = 1'b0;
    end
    if (rst) begin
      ex_req  = 1'b0;
      mc_done = 1'b0;
    end
  end

  // Single highest-priority stall pattern; a flush or reset clears it.
  always_comb begin
    stall  = '0;
    flush  = 1'b0;
    new_pc = '0;
    if (!rst) begin
      if (bus.flush_req) begin
        flush  = 1'b1;
        new_pc = bus.flush_pc;
      end else if (bus.stallreq_mem) begin
        stall = STG_W'(6'b011111);
      end else if (ex_req) begin
        stall = STG_W'(6'b001111);
      end else if (bus.stallreq_id) begin
        stall = STG_W'(6'b000111);
      end else if (bus.stallreq_if) begin
        stall = STG_W'(6'b000011);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.new_pc    = new_pc;
  assign bus.mc_done   = mc_done;
  assign bus.mc_busy   = (state_q == BUSY) && !rst;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: priority table, directed multi-cycle
// sequences, counter saturation, and a randomized run against a cycle model.
module tb_pipeline_ctrl;
  logic clk;
  logic rst;
  pipeline_ctrl_if pif ();

  pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(pif.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        s_if, s_id, s_mem, fl;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pif.stallreq_if = 0; pif.stallreq_id = 0; pif.stallreq_mem = 0;
    pif.mc_start = 0; pif.mc_len = 0; pif.flush_req = 0; pif.flush_pc = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Checks the cycle's outputs after inputs have been applied and settled.
  task automatic expect_out(input string tag, input logic [5:0] s, input logic d, input logic b);
    #1;
    check({tag, ".stall"}, 32'(pif.stall), 32'(s));
    check({tag, ".done"}, 32'(pif.mc_done), 32'(d));
    check({tag, ".busy"}, 32'(pif.mc_busy), 32'(b));
  endtask

  // Behavioural model state: op in flight and EX cycles it still needs.
  bit          m_active;
  int          m_left;
  longint      m_cnt;

  initial begin
    vec_t vt[8];
    rst = 1;
    idle_inputs();
    tick();
    tick();
    check("reset.stall", 32'(pif.stall), 32'h0);
    check("reset.busy", 32'(pif.mc_busy), 32'h0);
    rst = 0;
    #1;
    check("reset.stall_cnt", pif.stall_cnt, 32'h0);

    // Priority/flush table, sequencer idle.
    vt[0] = '{0,0,0,0,32'h0,        6'b000000,0,32'h0};
    vt[1] = '{1,0,0,0,32'h0,        6'b000011,0,32'h0};
    vt[2] = '{0,1,0,0,32'h0,        6'b000111,0,32'h0};
    vt[3] = '{0,0,1,0,32'h0,        6'b011111,0,32'h0};
    vt[4] = '{0,1,1,0,32'h0,        6'b011111,0,32'h0};
    vt[5] = '{1,1,0,0,32'h0,        6'b000111,0,32'h0};
    vt[6] = '{1,1,1,1,32'hDEAD_BEEF,6'b000000,1,32'hDEAD_BEEF};
    vt[7] = '{0,0,0,1,32'h0000_0180,6'b000000,1,32'h0000_0180};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      pif.stallreq_if = vt[i].s_if; pif.stallreq_id = vt[i].s_id;
      pif.stallreq_mem = vt[i].s_mem; pif.flush_req = vt[i].fl; pif.flush_pc = vt[i].pc;
      #1;
      check($sformatf("tbl%0d.stall", i), 32'(pif.stall), 32'(vt[i].e_stall));
      check($sformatf("tbl%0d.flush", i), 32'(pif.flush), 32'(vt[i].e_flush));
      check($sformatf("tbl%0d.new_pc", i), pif.new_pc, vt[i].e_pc);
      tick();
      idle_inputs();
      check($sformatf("tbl%0d.stall_cnt", i), pif.stall_cnt, 32'(vt[i].e_stall[0]));
    end

    // mc_len=5, with a mc_start while busy that must be ignored.
    do_reset();
    pif.mc_start = 1; pif.mc_len = 5;
    expect_out("mc5.T0", 6'b001111, 0, 0);
    tick(); idle_inputs();
    expect_out("mc5.T1", 6'b001111, 0, 1);
    tick(); pif.mc_start = 1; pif.mc_len = 2;
    expect_out("mc5.T2", 6'b001111, 0, 1);
    tick(); idle_inputs();
    expect_out("mc5.T3", 6'b001111, 0, 1);
    tick();
    expect_out("mc5.T4", 6'b000000, 1, 1);
    tick();
    expect_out("mc5.T5", 6'b000000, 0, 0);
    check("mc5.stall_cnt", pif.stall_cnt, 32'd4);

    // mc_len=5 frozen by MEM for two cycles starting at T+2.
    do_reset();
    pif.mc_start = 1; pif.mc_len = 5;
    expect_out("frz.T0", 6'b001111, 0, 0);
    tick(); idle_inputs();
    expect_out("frz.T1", 6'b001111, 0, 1);
    tick(); pif.stallreq_mem = 1;
    expect_out("frz.T2", 6'b011111, 0, 1);
    tick();
    expect_out("frz.T3", 6'b011111, 0, 1);
    tick(); pif.stallreq_mem = 0;
    expect_out("frz.T4", 6'b001111, 0, 1);
    tick();
    expect_out("frz.T5", 6'b001111, 0, 1);
    tick();
    expect_out("frz.T6", 6'b000000, 1, 1);
    tick();
    expect_out("frz.T7", 6'b000000, 0, 0);
    check("frz.stall_cnt", pif.stall_cnt, 32'd6);

    // Flush at T+2 abandons the op with no completion pulse.
    do_reset();
    pif.mc_start = 1; pif.mc_len = 5;
    expect_out("fl.T0", 6'b001111, 0, 0);
    tick(); idle_inputs();
    expect_out("fl.T1", 6'b001111, 0, 1);
    tick(); pif.flush_req = 1; pif.flush_pc = 32'h0000_0180; pif.stallreq_id = 1;
    expect_out("fl.T2", 6'b000000, 0, 1);
    check("fl.T2.flush", 32'(pif.flush), 32'h1);
    check("fl.T2.new_pc", pif.new_pc, 32'h0000_0180);
    for (int k = 3; k < 6; k++) begin
      tick(); idle_inputs();
      expect_out($sformatf("fl.T%0d", k), 6'b000000, 0, 0);
      check($sformatf("fl.T%0d.new_pc", k), pif.new_pc, 32'h0);
    end
    check("fl.stall_cnt", pif.stall_cnt, 32'd2);

    // Reset mid-op, then a single-cycle op causes no stall.
    do_reset();
    pif.mc_start = 1; pif.mc_len = 5;
    expect_out("rs.T0", 6'b001111, 0, 0);
    tick(); idle_inputs();
    expect_out("rs.T1", 6'b001111, 0, 1);
    tick(); rst = 1; pif.stallreq_mem = 1; pif.flush_req = 1; pif.flush_pc = 32'h1234;
    expect_out("rs.T2", 6'b000000, 0, 0);
    check("rs.T2.flush", 32'(pif.flush), 32'h0);
    check("rs.T2.new_pc", pif.new_pc, 32'h0);
    tick(); rst = 0; idle_inputs();
    expect_out("rs.T3", 6'b000000, 0, 0);
    check("rs.T3.stall_cnt", pif.stall_cnt, 32'h0);
    pif.mc_start = 1; pif.mc_len = 1;
    expect_out("rs.len1", 6'b000000, 0, 0);
    tick(); pif.mc_len = 0;
    expect_out("rs.len0", 6'b000000, 0, 0);
    tick(); idle_inputs();
    expect_out("rs.after", 6'b000000, 0, 0);

    // Counter saturation from a preloaded value near the top.
    do_reset();
    pif.stallreq_if = 1;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    release dut.stall_cnt_q;
    tick();
    check("sat.1", pif.stall_cnt, 32'hFFFF_FFFE);
    tick();
    check("sat.2", pif.stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat.3", pif.stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat.4", pif.stall_cnt, 32'hFFFF_FFFF);

    // Randomized run against the cycle model.
    do_reset();
    m_active = 0; m_left = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0]  e_stall;
      logic        e_done, e_busy, e_flush, ex;
      logic [31:0] e_pc;
      rst              = ($urandom_range(0, 199) == 0);
      pif.stallreq_if  = ($urandom_range(0, 5) == 0);
      pif.stallreq_id  = ($urandom_range(0, 5) == 0);
      pif.stallreq_mem = ($urandom_range(0, 5) == 0);
      pif.mc_start     = ($urandom_range(0, 3) == 0);
      pif.mc_len       = 6'($urandom_range(0, 9));
      pif.flush_req    = ($urandom_range(0, 24) == 0);
      pif.flush_pc     = $urandom;

      e_busy = m_active && !rst;
      ex = 0; e_done = 0;
      if (rst) begin
        m_active = 0; m_left = 0;
      end else begin
        if (m_active) begin
          if (m_left > 1) begin
            ex = 1;
            if (!pif.stallreq_mem) m_left--;
          end else if (!pif.stallreq_mem) begin
            e_done = 1; m_active = 0;
          end
        end else if (pif.mc_start && pif.mc_len >= 2) begin
          ex = 1; m_active = 1; m_left = int'(pif.mc_len) - 1;
        end
        if (pif.flush_req) begin
          m_active = 0; e_done = 0;
        end
      end
      e_flush = !rst && pif.flush_req;
      e_pc    = e_flush ? pif.flush_pc : 32'h0;
      if (rst || pif.flush_req) e_stall = 6'b000000;
      else if (pif.stallreq_mem) e_stall = 6'b011111;
      else if (ex)               e_stall = 6'b001111;
      else if (pif.stallreq_id)  e_stall = 6'b000111;
      else if (pif.stallreq_if)  e_stall = 6'b000011;
      else                       e_stall = 6'b000000;

      #1;
      check($sformatf("rnd%0d.stall", cyc), 32'(pif.stall), 32'(e_stall));
      check($sformatf("rnd%0d.flush", cyc), 32'(pif.flush), 32'(e_flush));
      check($sformatf("rnd%0d.new_pc", cyc), pif.new_pc, e_pc);
      check($sformatf("rnd%0d.done", cyc), 32'(pif.mc_done), 32'(e_done));
      check($sformatf("rnd%0d.busy", cyc), 32'(pif.mc_busy), 32'(e_busy));
      check($sformatf("rnd%0d.stall_cnt", cyc), pif.stall_cnt, 32'(m_cnt));

      if (rst) m_cnt = 0;
      else if (e_stall[0] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
